lsu_mem_if: RTL and testbench
=============================

# lsu_mem_if

Load/store unit between the execute stage and the data RAM of the RISC-V core. It turns a load/store request (address from the ALU, store data from rs2, funct3) into a word-aligned, byte-enabled request to a variable-latency data memory. It stalls the core until the memory acknowledges. The formatted load result goes out on `ls_rdata`, which drives the `dram_rd` input of the write-back select stage.

## Interface
- `TIMEOUT_CYC`, default 255: number of BUSY cycles without `mem_ack` before the access is aborted with an error (≥1).
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ls_req` in 1: a memory instruction is present this cycle.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_funct3` in 3: RV32I load/store funct3.
- `ls_addr` in 32: byte address (ALU result).
- `ls_wdata` in 32: store data (rs2).
- `ls_stall` out 1: freeze PC and pipeline state.
- `ls_done` out 1: one-cycle completion pulse; `ls_rdata` and `ls_err` are valid in this cycle.
- `ls_rdata` out 32: formatted load data, to write-back `dram_rd`.
- `ls_err` out 1: misaligned access, illegal funct3, or timeout.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: `{ls_addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables; only meaningful for writes, all 1111 on reads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: access complete.

## Operation
- State machine: IDLE, BUSY, DONE.
- **IDLE**
  - `ls_stall = ls_req`, computed combinationally.
  - On `ls_req`, decode the request.
  - Legal and aligned: register `mem_addr`, `mem_we`, `mem_be` and `mem_wdata`, set `mem_req`, clear the timeout counter, go to BUSY.
  - Illegal or misaligned: no memory access. Go to DONE with `ls_err` = 1 and `ls_rdata` = 0.
- **BUSY**
  - `ls_stall` = 1.
  - `mem_*` outputs stay stable while waiting.
  - On `mem_ack`: deassert `mem_req` and capture the formatted load data (0 for stores). Go to DONE with `ls_err` = 0.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYC`: deassert `mem_req`, set `ls_err` = 1 and `ls_rdata` = 0, go to DONE.
  - If `mem_ack` and timeout happen in the same cycle, `mem_ack` wins.
- **DONE**
  - `ls_done` = 1 and `ls_stall` = 0, so the core commits and the PC advances.
  - `ls_req` is ignored in this cycle.
  - Always returns to IDLE. A back-to-back memory instruction is accepted in the following IDLE cycle.
- **Alignment and legal funct3**
  - Half accesses (funct3 001/101) are misaligned if `ls_addr[0]` = 1.
  - Word accesses (010) are misaligned if `ls_addr[1:0]` ≠ 0.
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Anything else is illegal.
- **Store lanes**
  - SB: `be = 4'b0001 << a[1:0]`, wdata = `{4{rs2[7:0]}}`.
  - SH: `be = a[1] ? 1100 : 0011`, wdata = `{2{rs2[15:0]}}`.
  - SW: `be = 1111`, wdata = rs2.
- **Load formatting**
  - The byte is selected by `a[1:0]`; the half by `a[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `mem_ack` is ignored in IDLE and DONE.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge):
  - State returns to IDLE and the counter clears.
  - `mem_req`, `mem_we`, `ls_done` and `ls_err` are 0.
  - `mem_addr`, `mem_wdata`, `ls_rdata` are 0; `mem_be` = 0000.
  - Reset mid-BUSY drops `mem_req` at that edge; a later `mem_ack` is ignored.
- **Minimum latency**
  - Cycle 0: IDLE accepts the request.
  - Cycle 1: BUSY, `mem_req` = 1, ack arrives.
  - Cycle 2: DONE.
  - `ls_stall` is high for 2 cycles.
- An ack arriving k cycles after `mem_req` rises gives stall = k+2 cycles.
- Error-on-decode path: stall for 1 cycle, DONE in cycle 1.
- Timeout path: `ls_done` with `ls_err` comes `TIMEOUT_CYC` + 1 cycles after the request rises.
- Counter width: `$clog2(TIMEOUT_CYC+1)` bits; it saturates and never wraps.

## Test plan
- **LB sign extension:** addr 0x1003, funct3 000, memory returns 0x80FF_0000 with ack in its first cycle → `mem_addr` 0x1000, stall for 2 cycles, `ls_rdata` 0xFFFF_FF80.
- **LHU, delayed ack:** addr 0x2002, funct3 101, rdata 0xBEEF_1234, ack 3 cycles late → `ls_rdata` 0x0000_BEEF, stall for 5 cycles.
- **SB:** addr 0x3001, rs2 0x1234_56AB → `mem_be` 0010, `mem_wdata` 0xABAB_ABAB, `mem_we` 1, `ls_rdata` 0.
- **Misaligned LW:** addr 0x4002 → no `mem_req` ever asserted; `ls_done` and `ls_err` = 1 in cycle 1; illegal funct3 011 gives the same result.
- **Timeout:** `TIMEOUT_CYC` = 4, no ack → `mem_req` high for 4 cycles, then `ls_err` = 1 and `ls_rdata` = 0. A variant with ack on the 4th cycle must complete without error.
- **Back-to-back and reset:**
  - Back-to-back: SW then LW with `ls_req` held high → the second request starts only after the DONE cycle.
  - Reset: `rst_n` low during BUSY → `mem_req` is 0 after that edge; a subsequent ack produces no `ls_done`.

Source files
------------

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the execute stage and the data RAM.
// It turns an RV32I load/store request into a word-aligned, byte-enabled
// access to a variable-latency memory. The core stalls until the access
// completes. The formatted load result is presented for one cycle on
// ls_rdata, alongside the ls_done pulse.
//
// Parameters
//   TIMEOUT_CYC : BUSY cycles without mem_ack before the access is aborted (>=1)
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   ls_req, ls_we     : request present / store (1) or load (0)
//   ls_funct3         : RV32I load/store funct3
//   ls_addr, ls_wdata : byte address, store data (rs2)
//   ls_stall          : freeze PC and pipeline
//   ls_done           : one-cycle completion pulse; ls_rdata/ls_err valid with it
//   ls_rdata, ls_err  : formatted load data; misaligned/illegal/timeout flag
//   mem_req, mem_we   : memory request (held until ack), write enable
//   mem_addr, mem_be  : word address, byte enables (1111 on reads)
//   mem_wdata         : lane-replicated store data
//   mem_rdata, mem_ack: read data, access complete
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_stall,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          ls_done_q;
  logic          ls_err_q;
  logic [31:0]   ls_rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;

  logic          dec_legal;
  logic [3:0]    dec_be;
  logic [31:0]   dec_wdata;
  logic [31:0]   load_fmt;

  // Request decode: legality/alignment plus store lane placement.
  always_comb begin
    dec_legal = 1'b0;
    dec_be    = '1;
    dec_wdata = ls_wdata;
    case (ls_funct3)
      3'b000: begin
        dec_legal = 1'b1;
        if (ls_we) begin
          dec_be    = 4'b0001 << ls_addr[1:0];
          dec_wdata = {4{ls_wdata[7:0]}};
        end
      end
      3'b001: begin
        dec_legal = ~ls_addr[0];
        if (ls_we) begin
          dec_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
          dec_wdata = {2{ls_wdata[15:0]}};
        end
      end
      3'b010:  dec_legal = (ls_addr[1:0] == 2'b00);
      3'b100:  dec_legal = ~ls_we;
      3'b101:  dec_legal = ~ls_we & ~ls_addr[0];
      default: dec_legal = 1'b0;
    endcase
  end

  // Load formatting uses the funct3 and byte offset captured at accept time.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (off_q)
      2'd0:    b = mem_rdata[7:0];
      2'd1:    b = mem_rdata[15:8];
      2'd2:    b = mem_rdata[23:16];
      default: b = mem_rdata[31:24];
    endcase
    h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b100:  load_fmt = {24'd0, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Saturating wait counter; the abort fires in the BUSY cycle that brings it to CNT_MAX.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ls_done_q <= 1'b0;
          if (ls_req) begin
            if (dec_legal) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= ls_we;
              mem_addr_q  <= {ls_addr[31:2], 2'b00};
              mem_be_q    <= dec_be;
              mem_wdata_q <= dec_wdata;
              f3_q        <= ls_funct3;
              off_q       <= ls_addr[1:0];
              cnt_q       <= '0;
              state_q     <= S_BUSY;
            end else begin
              ls_err_q   <= 1'b1;
              ls_rdata_q <= '0;
              ls_done_q  <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          // An ack in the same cycle as the timeout takes priority.
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            ls_rdata_q <= mem_we_q ? '0 : load_fmt;
            ls_err_q   <= 1'b0;
            ls_done_q  <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_MAX) begin
              mem_req_q  <= 1'b0;
              ls_rdata_q <= '0;
              ls_err_q   <= 1'b1;
              ls_done_q  <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          ls_done_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ls_stall = (state_q == S_BUSY) | ((state_q == S_IDLE) & ls_req);
  end

  assign ls_done   = ls_done_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed self-checking bench for lsu_mem_if (TIMEOUT_CYC = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_lsu_mem_if;

  logic        clk;
  logic        rst_n;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_stall;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  lsu_mem_if #(.TIMEOUT_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_funct3(ls_funct3),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_stall (ls_stall),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .ls_err   (ls_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle();
    @(negedge clk);
    ls_req  = 1'b0;
    mem_ack = 1'b0;
  endtask

  // One transaction. ack_dly = number of mem_req cycles before the ack
  // (0 = ack in the first one), negative = never ack. ls_req is left high.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrdata, input int ack_dly,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_done, input int exp_req,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    int          stall_n = 0;
    int          req_n = 0;
    int          done_c = -1;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = '0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic [3:0]  c_be = '0;
    logic        c_we = 1'b0;
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
    mem_ack = 1'b0;
    check({tag, "_idle"}, {30'd0, ls_done, mem_req}, 32'd0);
    #1;
    if (ls_stall) stall_n++;
    for (int c = 1; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (ls_done) begin
        done_c    = c;
        got_err   = ls_err;
        got_rdata = ls_rdata;
        mem_ack   = 1'b0;
        #1;
        check({tag, "_stall_in_done"}, {31'd0, ls_stall}, 32'd0);
      end else begin
        if (mem_req) begin
          if (req_n == 0) begin
            c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
          end
          req_n++;
          if (ack_dly >= 0 && req_n - 1 == ack_dly) begin
            mem_ack = 1'b1; mem_rdata = mrdata;
          end else begin
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
          end
        end else begin
          mem_ack = 1'b0;
        end
        #1;
        if (ls_stall) stall_n++;
      end
    end
    if (done_c < 0) begin
      check({tag, "_no_done"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_done_cyc"}, done_c, exp_done);
      check({tag, "_stall_cyc"}, stall_n, exp_done);
      check({tag, "_req_cyc"}, req_n, exp_req);
      check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
      check({tag, "_rdata"}, got_rdata, exp_rdata);
      if (exp_req > 0) begin
        check({tag, "_addr"}, c_addr, exp_addr);
        check({tag, "_be"}, {28'd0, c_be}, {28'd0, exp_be});
        check({tag, "_we"}, {31'd0, c_we}, {31'd0, we});
        if (we) check({tag, "_wdata"}, c_wdata, exp_wdata);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0;
    ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_done_err", {30'd0, ls_done, ls_err}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", ls_rdata, 32'd0);
    rst_n = 1'b1;

    //     tag        we  f3      addr          wdata          mrdata         dly err rdata          done req exp_addr      be       exp_wdata
    run_op("lb_sext",  0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_0000,  0, 0, 32'hFFFF_FF80, 2, 1, 32'h0000_1000, 4'b1111, 32'h0);
    idle();
    run_op("lhu_dly",  0, 3'b101, 32'h0000_2002, 32'h0,         32'hBEEF_1234,  3, 0, 32'h0000_BEEF, 5, 4, 32'h0000_2000, 4'b1111, 32'h0);
    idle();
    run_op("sb",       1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0,          0, 0, 32'h0,         2, 1, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB);
    idle();
    run_op("sh_hi",    1, 3'b001, 32'h0000_5002, 32'hAAAA_5678, 32'h0,          1, 0, 32'h0,         3, 2, 32'h0000_5000, 4'b1100, 32'h5678_5678);
    idle();
    run_op("lh_sext",  0, 3'b001, 32'h0000_6000, 32'h0,         32'h1234_8001,  0, 0, 32'hFFFF_8001, 2, 1, 32'h0000_6000, 4'b1111, 32'h0);
    idle();
    run_op("lbu",      0, 3'b100, 32'h0000_6001, 32'h0,         32'h0000_F000,  0, 0, 32'h0000_00F0, 2, 1, 32'h0000_6000, 4'b1111, 32'h0);
    idle();
    run_op("mis_lw",   0, 3'b010, 32'h0000_4002, 32'h0,         32'h0,         -1, 1, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
    idle();
    run_op("ill_f3",   0, 3'b011, 32'h0000_4000, 32'h0,         32'h0,         -1, 1, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
    idle();
    run_op("ill_st",   1, 3'b100, 32'h0000_4000, 32'h0,         32'h0,         -1, 1, 32'h0,         1, 0, 32'h0,         4'b0000, 32'h0);
    idle();
    run_op("tmo",      0, 3'b010, 32'h0000_8000, 32'h0,         32'h0,         -1, 1, 32'h0,         5, 4, 32'h0000_8000, 4'b1111, 32'h0);
    idle();
    run_op("tmo_ack4", 0, 3'b010, 32'h0000_8000, 32'h0,         32'hCAFE_F00D,  3, 0, 32'hCAFE_F00D, 5, 4, 32'h0000_8000, 4'b1111, 32'h0);
    idle();
    // Back-to-back: ls_req stays high through the SW DONE cycle.
    run_op("b2b_sw",   1, 3'b010, 32'h0000_9004, 32'h1122_3344, 32'h0,          0, 0, 32'h0,         2, 1, 32'h0000_9004, 4'b1111, 32'h1122_3344);
    run_op("b2b_lw",   0, 3'b010, 32'h0000_9004, 32'h0,         32'h5566_7788,  1, 0, 32'h5566_7788, 3, 2, 32'h0000_9004, 4'b1111, 32'h0);
    idle();

    // Reset while BUSY, then a stray ack must not complete anything.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0000_7000;
    @(negedge clk);
    check("rstb_busy_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ls_req = 1'b0;
    #1;
    check("rstb_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstb_stall", {31'd0, ls_stall}, 32'd0);
    check("rstb_addr", mem_addr, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstb_no_done", {31'd0, ls_done}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
